// File: rtl/hci_stride_datamover.sv
// Strided TCDM data mover: issues count accesses at base + i*stride, writing an
// index-derived pattern, or reading it back to accumulate a checksum and count mismatches.
module hci_stride_datamover #(
  parameter int unsigned HWPE_WIDTH_FACT = 4,
  parameter int unsigned AW              = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned DW             = 32 * HWPE_WIDTH_FACT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [AW-1:0]    base_i,
  input  logic [AW-1:0]    stride_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [31:0]      seed_i,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [AW-1:0]    add_o,
  output logic             wen_o,
  output logic [DW/8-1:0]  be_o,
  output logic [DW-1:0]    data_o,
  input  logic             r_valid_i,
  input  logic [DW-1:0]    r_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [31:0]      checksum_o,
  output logic [1:0]       state_o
);

  localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] WF32 = 32'(HWPE_WIDTH_FACT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [AW-1:0]    addr_q, stride_q;
  logic [CNT_W-1:0] count_q, idx_q, err_q;
  logic [31:0]      wr_pat_q, chk_pat_q, cks_q;
  logic [OW-1:0]    outst_q, outst_d;

  logic          is_write, is_chk, in_issue;
  logic          gnt_fire, rsp_fire, last_gnt;
  logic [31:0]   rsp_xor;
  logic          rsp_bad;
  logic [DW-1:0] wr_data;

  assign is_write = (mode_q == 2'b01);
  assign is_chk   = (mode_q == 2'b10);
  assign in_issue = (state_q == S_ISSUE);

  // Request side is valid/ready: req_o is the valid, gnt_i the ready; a transfer happens
  // on req_o & gnt_i. req_o depends only on registered state, so once raised it holds
  // (outstanding can only fall without a grant) and the payload is frozen until granted.
  assign req_o    = in_issue && (outst_q < OW'(MAX_OUTSTANDING));
  assign gnt_fire = req_o & gnt_i;
  assign rsp_fire = r_valid_i && (outst_q != '0);
  assign last_gnt = gnt_fire && (idx_q == count_q - CNT_W'(1));

  always_comb begin
    outst_d = outst_q;
    case ({gnt_fire, rsp_fire})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_comb begin
    rsp_xor = '0;
    rsp_bad = 1'b0;
    wr_data = '0;
    for (int k = 0; k < int'(HWPE_WIDTH_FACT); k++) begin
      rsp_xor               = rsp_xor ^ r_data_i[32*k +: 32];
      wr_data[32*k +: 32]   = wr_pat_q + 32'(k);
      if (r_data_i[32*k +: 32] != chk_pat_q + 32'(k)) rsp_bad = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (count_i == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_gnt) state_d = S_DRAIN;
      S_DRAIN: if (outst_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      err_q     <= '0;
      wr_pat_q  <= '0;
      chk_pat_q <= '0;
      cks_q     <= '0;
      outst_q   <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (state_q == S_IDLE && start_i) begin
        mode_q    <= mode_i;
        addr_q    <= base_i;
        stride_q  <= stride_i;
        count_q   <= count_i;
        idx_q     <= '0;
        err_q     <= '0;
        cks_q     <= '0;
        wr_pat_q  <= seed_i;
        chk_pat_q <= seed_i;
      end
      if (gnt_fire) begin
        idx_q    <= idx_q + CNT_W'(1);
        addr_q   <= addr_q + stride_q;
        wr_pat_q <= wr_pat_q + WF32;
      end
      // chk_pat_q tracks seed + j*WF for the response index j
      if (rsp_fire) begin
        chk_pat_q <= chk_pat_q + WF32;
        if (!is_write) cks_q <= cks_q ^ rsp_xor;
        if (is_chk && rsp_bad && (err_q != '1)) err_q <= err_q + CNT_W'(1);
      end
    end
  end

  assign add_o      = in_issue ? addr_q : '0;
  assign wen_o      = in_issue & ~is_write;
  assign be_o       = {(DW/8){in_issue}};
  assign data_o     = (in_issue && is_write) ? wr_data : '0;
  assign busy_o     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign err_cnt_o  = err_q;
  assign checksum_o = cks_q;
  assign state_o    = state_q;

endmodule

// File: doc/hci_stride_datamover.md
HCI_STRIDE_DATAMOVER -- requirements
Module: hci_stride_datamover

Interface
REQ-001 Parameter HWPE_WIDTH_FACT, default 4: data width as a multiple of 32-bit core words; DW = 32*HWPE_WIDTH_FACT.
REQ-002 Parameter AW, default 32: TCDM address width.
REQ-003 Parameter MAX_OUTSTANDING, default 4: maximum granted-but-unanswered requests; range 1..16.
REQ-004 Parameter CNT_W, default 16: width of the transfer-count and error-count fields.
REQ-005 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 start_i  in  1  one-cycle start pulse; sampled only in IDLE.
REQ-008 mode_i  in  2  00 read, 01 write-pattern, 10 read-check, 11 reserved (treated as 00).
REQ-009 base_i  in  AW  start byte address.
REQ-010 stride_i  in  AW  byte stride between consecutive accesses.
REQ-011 count_i  in  CNT_W  number of accesses.
REQ-012 seed_i  in  32  pattern seed.
REQ-013 req_o, gnt_i  out/in  1  TCDM request handshake.
REQ-014 add_o  out  AW;  wen_o  out  1 (1 = read, 0 = write);  be_o  out  DW/8;  data_o  out  DW.
REQ-015 r_valid_i  in  1;  r_data_i  in  DW  in-order response, one per granted request, reads and writes alike.
REQ-016 busy_o  out  1;  done_o  out  1 (one-cycle pulse);  err_cnt_o  out  CNT_W;  checksum_o  out  32.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; start_i in IDLE latches mode, base, stride, count and seed, clears err_cnt_o and checksum_o, and moves to ISSUE, or to DONE when count_i = 0.
REQ-018 Request index i runs 0..count-1; add_o = base + i*stride, truncated mod 2^AW so it wraps silently.
REQ-019 be_o is all ones; wen_o = 0 only in write-pattern mode.
REQ-020 Pattern: 32-bit lane k of word i = seed + i*HWPE_WIDTH_FACT + k, mod 2^32; data_o carries it in write mode and is 0 otherwise.
REQ-021 req_o asserts in ISSUE only while outstanding < MAX_OUTSTANDING; an r_valid_i in the same cycle does not unlock issue that cycle.
REQ-022 Once req_o is high, add_o, wen_o, be_o and data_o stay stable, and req_o stays high until gnt_i.
REQ-023 A handshake is req_o & gnt_i; it increments i and the outstanding count.
REQ-024 r_valid_i decrements the outstanding count; a grant and a response in the same cycle leave the count unchanged.
REQ-025 After the last grant the FSM moves ISSUE -> DRAIN, and DRAIN -> DONE when outstanding = 0 with no grant pending.
REQ-026 DONE lasts one cycle with done_o = 1, then returns to IDLE; busy_o = 1 in ISSUE and DRAIN only.
REQ-027 In read and read-check modes, each response XORs all 32-bit lanes of r_data_i into checksum_o.
REQ-028 Read-check: a response-index counter j tracks responses; any lane mismatch against the REQ-020 pattern for index j increments err_cnt_o by 1 per word, saturating at 2^CNT_W-1.
REQ-029 In write mode, responses affect only the outstanding count.
REQ-030 r_valid_i with outstanding = 0 is ignored and the count does not underflow.
REQ-031 start_i outside IDLE is ignored.
REQ-032 err_cnt_o and checksum_o hold their values after DONE until the next accepted start.

Reset
REQ-033 Asserting rst_ni low immediately forces the state to IDLE and i, j and outstanding to 0.
REQ-034 During reset, req_o, wen_o, busy_o and done_o = 0 and add_o, be_o, data_o, err_cnt_o and checksum_o = 0, including mid-transfer.
REQ-035 Responses to requests granted before reset are not tracked after reset.

Verification
REQ-036 Write mode, base 0x100, stride 16, count 4, seed 0, WF=4, gnt_i tied 1, 1-cycle responses -> addresses 0x100, 0x110, 0x120, 0x130; word 1 lanes = 4,5,6,7; done_o pulses once.
REQ-037 Read-check after the REQ-036 write, memory model correct -> err_cnt_o = 0 and checksum_o = XOR of values 0..15 = 0; with word 2 lane 0 corrupted -> err_cnt_o = 1.
REQ-038 MAX_OUTSTANDING = 2, responses delayed 5 cycles, count 6 -> never more than 2 unanswered grants; req_o deasserts at the limit; done_o fires after the 6th response.
REQ-039 Random gnt_i stalls -> add_o and data_o stay constant while req_o is high and gnt_i is low; exactly count grants occur.
REQ-040 count 0 -> done_o one cycle after start, no req_o; base 0xFFFF_FFF0, stride 16, count 2 -> second address 0x0000_0000.
REQ-041 rst_ni asserted in ISSUE with 3 outstanding -> all outputs 0 immediately; a new start after release runs normally.
